sprite_pixel_writer: RTL and testbench

Downstream consumer of the graphic control unit. Each HF_CLK it takes the sprite-local coordinate (SID_CLM/SID_ROW), screen coordinate (PGA_CLM/PGA_ROW) and current instruction, fetches the sprite texel from a synchronous sprite ROM, and issues a clipped, transparency-masked write into the 640x480 frame buffer. Three-stage pipeline, writes only during blanking; also keeps write/drop statistics.

---
 rtl/sprite_pixel_writer.sv | 124 ++++++++++++
 tb/tb_sprite_pixel_writer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_writer.sv
// sprite_pixel_writer: three-stage sprite texel writer into a 640x480 frame buffer.
// S0 captures the screen coordinate and instruction while the sprite ROM is addressed,
// S1 waits for the ROM and precomputes clip/invisible flags and the linear address,
// S2 writes the non-transparent, on-screen texel. Writes happen only during blanking.
//
// Ports:
//   HF_CLK       clock
//   RST          synchronous active-high reset
//   BLANK        1 = blanking interval, writes permitted; 0 flushes the pipeline
//   CURRENT_INS  [31:22] x origin, [21:13] y origin, [12:10] mode, [9:4] sprite id
//   SID_CLM/ROW  sprite-local column/row
//   PGA_CLM/ROW  screen column/row
//   ROM_ADDR     sprite ROM address {sprite id, SID_ROW, SID_CLM}, combinational
//   ROM_DATA     texel, valid one cycle after ROM_ADDR; 8'h00 is transparent
//   FB_WE        one-cycle frame-buffer write strobe
//   FB_ADDR      PGA_ROW*H_RES + PGA_CLM
//   FB_DATA      texel written
//   WR_CNT       saturating count of writes issued
//   DROP_CNT     saturating count of clipped, invisible or transparent texels
module sprite_pixel_writer #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned CNT_W = 16
) (
    input  logic             HF_CLK,
    input  logic             RST,
    input  logic             BLANK,
    input  logic [31:0]      CURRENT_INS,
    input  logic [4:0]       SID_CLM,
    input  logic [4:0]       SID_ROW,
    input  logic [9:0]       PGA_CLM,
    input  logic [9:0]       PGA_ROW,
    output logic [15:0]      ROM_ADDR,
    input  logic [7:0]       ROM_DATA,
    output logic             FB_WE,
    output logic [18:0]      FB_ADDR,
    output logic [7:0]       FB_DATA,
    output logic [CNT_W-1:0] WR_CNT,
    output logic [CNT_W-1:0] DROP_CNT
);

    localparam int unsigned ADDR_W = 19;
    localparam logic [2:0]  MODE_INVISIBLE = 3'b111;

    // S1 (ROM wait) stage
    logic              valid1;
    logic [9:0]        col1;
    logic [9:0]        row1;
    logic [2:0]        mode1;

    // S2 (write) stage
    logic              valid2;
    logic              clip2;
    logic              invis2;
    logic [ADDR_W-1:0] addr2;
    logic [7:0]        texel2;

    logic              clip1_c;
    logic              invis1_c;
    logic [ADDR_W-1:0] addr1_c;
    logic              issue_c;
    logic              drop_c;
    logic              unused_ins;

    // ROM is addressed straight from the live inputs so its data lines up with S1->S2.
    assign ROM_ADDR   = {CURRENT_INS[9:4], SID_ROW, SID_CLM};
    assign unused_ins = ^{CURRENT_INS[31:13], CURRENT_INS[3:0]};

    // Clip/visibility decode and linear address; the address stays zero for clipped
    // coordinates so an off-screen product is never formed.
    always_comb begin
        clip1_c  = (32'(col1) >= H_RES) || (32'(row1) >= V_RES);
        invis1_c = (mode1 == MODE_INVISIBLE);
        addr1_c  = '0;
        if (!clip1_c) begin
            addr1_c = ADDR_W'(row1) * ADDR_W'(H_RES) + ADDR_W'(col1);
        end
    end

    // Write/drop decision; BLANK low squashes the S2 entry without counting it.
    always_comb begin
        issue_c = valid2 && !clip2 && !invis2 && (texel2 != 8'h00) && BLANK;
        drop_c  = valid2 && BLANK && !issue_c;
    end

    // Control, outputs and statistics.
    always_ff @(posedge HF_CLK) begin
        if (RST) begin
            valid1   <= 1'b0;
            valid2   <= 1'b0;
            FB_WE    <= 1'b0;
            FB_ADDR  <= '0;
            FB_DATA  <= '0;
            WR_CNT   <= '0;
            DROP_CNT <= '0;
        end else begin
            valid1 <= BLANK;
            valid2 <= valid1 && BLANK;
            FB_WE  <= issue_c;
            if (issue_c) begin
                FB_ADDR <= addr2;
                FB_DATA <= texel2;
            end
            if (issue_c && (WR_CNT != {CNT_W{1'b1}})) begin
                WR_CNT <= WR_CNT + CNT_W'(1);
            end
            if (drop_c && (DROP_CNT != {CNT_W{1'b1}})) begin
                DROP_CNT <= DROP_CNT + CNT_W'(1);
            end
        end
    end

    // Datapath registers; qualified by the valid bits so they need no reset.
    always_ff @(posedge HF_CLK) begin
        col1   <= PGA_CLM;
        row1   <= PGA_ROW;
        mode1  <= CURRENT_INS[12:10];
        clip2  <= clip1_c;
        invis2 <= invis1_c;
        addr2  <= addr1_c;
        texel2 <= ROM_DATA;
    end

endmodule

// File: tb/tb_sprite_pixel_writer.sv
module tb_sprite_pixel_writer;

    logic        HF_CLK = 1'b0;
    logic        RST;
    logic        BLANK;
    logic [31:0] CURRENT_INS;
    logic [4:0]  SID_CLM;
    logic [4:0]  SID_ROW;
    logic [9:0]  PGA_CLM;
    logic [9:0]  PGA_ROW;
    logic [15:0] ROM_ADDR;
    logic [7:0]  ROM_DATA;
    logic        FB_WE;
    logic [18:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic [15:0] WR_CNT;
    logic [15:0] DROP_CNT;

    logic [15:0] s_rom_addr;
    logic        s_we;
    logic [18:0] s_addr;
    logic [7:0]  s_data;
    logic [3:0]  s_wr;
    logic [3:0]  s_drop;

    always #5 HF_CLK = ~HF_CLK;

    sprite_pixel_writer u_dut (
        .HF_CLK(HF_CLK), .RST(RST), .BLANK(BLANK), .CURRENT_INS(CURRENT_INS),
        .SID_CLM(SID_CLM), .SID_ROW(SID_ROW), .PGA_CLM(PGA_CLM), .PGA_ROW(PGA_ROW),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR),
        .FB_DATA(FB_DATA), .WR_CNT(WR_CNT), .DROP_CNT(DROP_CNT)
    );

    sprite_pixel_writer #(.CNT_W(4)) u_sat (
        .HF_CLK(HF_CLK), .RST(RST), .BLANK(BLANK), .CURRENT_INS(CURRENT_INS),
        .SID_CLM(SID_CLM), .SID_ROW(SID_ROW), .PGA_CLM(PGA_CLM), .PGA_ROW(PGA_ROW),
        .ROM_ADDR(s_rom_addr), .ROM_DATA(ROM_DATA), .FB_WE(s_we), .FB_ADDR(s_addr),
        .FB_DATA(s_data), .WR_CNT(s_wr), .DROP_CNT(s_drop)
    );

    // Synchronous sprite ROM: one cycle from address to data.
    logic [7:0] rom_mem [0:65535];
    always @(posedge HF_CLK) ROM_DATA <= rom_mem[ROM_ADDR];

    int checks = 0;
    int errors = 0;

    // Reference model: each captured texel is resolved two edges later if blanking
    // held throughout; any non-blank edge or reset discards everything pending.
    typedef struct {
        int c;
        int r;
        int mode;
        int tex;
    } ent_t;
    ent_t        pend[$];
    bit          exp_we;
    logic [18:0] exp_addr;
    logic [7:0]  exp_data;
    int unsigned exp_wr;
    int unsigned exp_drop;

    function automatic int unsigned satn(input int unsigned n, input int unsigned w);
        int unsigned m;
        m = (32'd1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    task automatic tick();
        ent_t e;
        logic [15:0] a;
        @(posedge HF_CLK);
        if (RST) begin
            pend.delete();
            exp_we = 0; exp_addr = '0; exp_data = '0; exp_wr = 0; exp_drop = 0;
        end else if (!BLANK) begin
            pend.delete();
            exp_we = 0;
        end else begin
            exp_we = 0;
            if (pend.size() == 2) begin
                e = pend.pop_front();
                if (e.c < 640 && e.r < 480 && e.mode != 7 && e.tex != 0) begin
                    exp_we   = 1;
                    exp_addr = 19'(e.r * 640 + e.c);
                    exp_data = 8'(e.tex);
                    exp_wr++;
                end else begin
                    exp_drop++;
                end
            end
            a      = {CURRENT_INS[9:4], SID_ROW, SID_CLM};
            e.c    = int'(PGA_CLM);
            e.r    = int'(PGA_ROW);
            e.mode = int'(CURRENT_INS[12:10]);
            e.tex  = int'(rom_mem[a]);
            pend.push_back(e);
        end
        #1;
    endtask

    task automatic set_px(input bit blank, input bit [5:0] id, input bit [2:0] mode,
                          input bit [4:0] sc, input bit [4:0] sr,
                          input bit [9:0] pc, input bit [9:0] pr);
        BLANK       = blank;
        CURRENT_INS = {10'($urandom), 9'($urandom), mode, id, 4'($urandom)};
        SID_CLM     = sc;
        SID_ROW     = sr;
        PGA_CLM     = pc;
        PGA_ROW     = pr;
    endtask

    // Present one blanking-time pixel whose ROM texel is forced to tex.
    task automatic put(input bit [9:0] pc, input bit [9:0] pr, input bit [2:0] mode,
                       input bit [7:0] tex);
        bit [5:0] id;
        bit [4:0] sc;
        bit [4:0] sr;
        id = 6'($urandom); sc = 5'($urandom); sr = 5'($urandom);
        rom_mem[{id, sr, sc}] = tex;
        set_px(1'b1, id, mode, sc, sr, pc, pr);
    endtask

    task automatic filler();
        put(10'd0, 10'd0, 3'd7, 8'h11);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_px(1'($urandom), 6'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                   10'($urandom), 10'($urandom));
            tick();
            checks++;
            if (FB_WE !== 1'b0 || FB_ADDR !== 19'd0 || FB_DATA !== 8'd0) begin
                errors++;
                $display("FAIL reset_out we=%0b addr=%0d data=%0h want 0/0/0", FB_WE, FB_ADDR, FB_DATA);
            end
            checks++;
            if (WR_CNT !== 16'd0 || DROP_CNT !== 16'd0 || s_wr !== 4'd0) begin
                errors++;
                $display("FAIL reset_cnt wr=%0d drop=%0d swr=%0d want 0", WR_CNT, DROP_CNT, s_wr);
            end
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_px(1'b0, 6'($urandom), 3'd0, 5'($urandom), 5'($urandom), 10'd1, 10'd1);
            tick();
            checks++;
            if (FB_WE !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle we=%0b want 0", FB_WE);
            end
        end
        put(10'd300, 10'd200, 3'd0, 8'h77);
        tick();
        checks++;
        if (FB_WE !== 1'b0) begin errors++; $display("FAIL first_cap we=%0b want 0", FB_WE); end
        filler();
        tick();
        checks++;
        if (FB_WE !== 1'b0) begin errors++; $display("FAIL first_cap1 we=%0b want 0", FB_WE); end
        filler();
        tick();
        checks++;
        if (FB_WE !== 1'b1 || FB_ADDR !== 19'd128300 || FB_DATA !== 8'h77) begin
            errors++;
            $display("FAIL first_write we=%0b addr=%0d data=%0h want 1/128300/77", FB_WE, FB_ADDR, FB_DATA);
        end
        BLANK = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int unsigned w0;
        w0 = exp_wr;
        rom_mem[{6'd5, 5'd2, 5'd3}] = 8'h3C;
        set_px(1'b1, 6'd5, 3'd0, 5'd3, 5'd2, 10'd100, 10'd50);
        #1;
        checks++;
        if (ROM_ADDR !== 16'h1443) begin
            errors++;
            $display("FAIL rom_addr got %h want 1443", ROM_ADDR);
        end
        tick();
        filler();
        tick();
        checks++;
        if (FB_WE !== 1'b0) begin errors++; $display("FAIL single_early we=%0b want 0", FB_WE); end
        filler();
        tick();
        checks++;
        if (FB_WE !== 1'b1 || FB_ADDR !== 19'd32100 || FB_DATA !== 8'h3C) begin
            errors++;
            $display("FAIL single_write we=%0b addr=%0d data=%0h want 1/32100/3c", FB_WE, FB_ADDR, FB_DATA);
        end
        checks++;
        if (WR_CNT !== 16'(w0 + 1)) begin
            errors++;
            $display("FAIL single_wrcnt got %0d want %0d", WR_CNT, w0 + 1);
        end
        tick();
        checks++;
        if (FB_WE !== 1'b0) begin errors++; $display("FAIL single_pulse we=%0b want 0", FB_WE); end
        BLANK = 1'b0;
        tick();
    endtask

    task automatic test_drop();
        int unsigned d0;
        d0 = exp_drop;
        put(10'd10, 10'd10, 3'd0, 8'h00);
        tick();
        put(10'd20, 10'd20, 3'd7, 8'h55);
        tick();
        for (int i = 0; i < 2; i++) begin
            filler();
            tick();
            checks++;
            if (FB_WE !== 1'b0) begin errors++; $display("FAIL drop_we step%0d we=%0b want 0", i, FB_WE); end
        end
        checks++;
        if (DROP_CNT !== 16'(d0 + 2)) begin
            errors++;
            $display("FAIL drop_cnt got %0d want %0d", DROP_CNT, d0 + 2);
        end
        BLANK = 1'b0;
        tick();
        checks++;
        if (DROP_CNT !== 16'(d0 + 2)) begin
            errors++;
            $display("FAIL drop_squash got %0d want %0d", DROP_CNT, d0 + 2);
        end
    endtask

    task automatic test_clip();
        int unsigned d0;
        int unsigned w0;
        bit [9:0] cx [4];
        bit [9:0] cy [4];
        cx = '{10'd639, 10'd640, 10'd5, 10'd1023};
        cy = '{10'd479, 10'd10, 10'd480, 10'd0};
        d0 = exp_drop;
        w0 = exp_wr;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) put(cx[i], cy[i], 3'd0, 8'hA5);
            else filler();
            tick();
            if (i == 2) begin
                checks++;
                if (FB_WE !== 1'b1 || FB_ADDR !== 19'd307199 || FB_DATA !== 8'hA5) begin
                    errors++;
                    $display("FAIL clip_corner we=%0b addr=%0d data=%0h want 1/307199/a5", FB_WE, FB_ADDR, FB_DATA);
                end
            end else if (i > 2) begin
                checks++;
                if (FB_WE !== 1'b0) begin errors++; $display("FAIL clip_we step%0d we=%0b want 0", i, FB_WE); end
            end
        end
        BLANK = 1'b0;
        tick();
        checks++;
        if (DROP_CNT !== 16'(d0 + 3) || WR_CNT !== 16'(w0 + 1)) begin
            errors++;
            $display("FAIL clip_cnt drop=%0d wr=%0d want %0d/%0d", DROP_CNT, WR_CNT, d0 + 3, w0 + 1);
        end
    endtask

    task automatic test_flush();
        int unsigned d0;
        int unsigned w0;
        int seen;
        d0 = exp_drop;
        w0 = exp_wr;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) put(10'(i + 1), 10'd7, 3'd0, 8'(8'h40 + i));
            else set_px(1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 10'd0, 10'd0);
            tick();
            if (FB_WE === 1'b1) begin
                checks++;
                if (seen >= 2 || FB_ADDR !== 19'(7 * 640 + seen + 1) || FB_DATA !== 8'(8'h40 + seen)) begin
                    errors++;
                    $display("FAIL flush_write n=%0d addr=%0d data=%0h want n<2 addr=%0d data=%0h",
                             seen, FB_ADDR, FB_DATA, 7 * 640 + seen + 1, 8'h40 + seen);
                end
                seen++;
            end
        end
        checks++;
        if (seen != 2) begin errors++; $display("FAIL flush_count got %0d writes want 2", seen); end
        checks++;
        if (DROP_CNT !== 16'(d0) || WR_CNT !== 16'(w0 + 2)) begin
            errors++;
            $display("FAIL flush_cnt drop=%0d wr=%0d want %0d/%0d", DROP_CNT, WR_CNT, d0, w0 + 2);
        end
    endtask

    task automatic test_reset_mid();
        put(10'd1, 10'd1, 3'd0, 8'h21);
        tick();
        put(10'd2, 10'd1, 3'd0, 8'h22);
        tick();
        RST = 1'b1;
        put(10'd3, 10'd1, 3'd0, 8'h23);
        tick();
        checks++;
        if (FB_WE !== 1'b0 || WR_CNT !== 16'd0 || DROP_CNT !== 16'd0) begin
            errors++;
            $display("FAIL rstmid we=%0b wr=%0d drop=%0d want 0/0/0", FB_WE, WR_CNT, DROP_CNT);
        end
        RST = 1'b0;
        put(10'd4, 10'd1, 3'd0, 8'h24);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (FB_WE !== 1'(i == 2)) begin
                errors++;
                $display("FAIL rstmid_after step%0d we=%0b want %0b", i, FB_WE, i == 2);
            end
            filler();
        end
        checks++;
        if (FB_ADDR !== 19'd644 || FB_DATA !== 8'h24) begin
            errors++;
            $display("FAIL rstmid_data addr=%0d data=%0h want 644/24", FB_ADDR, FB_DATA);
        end
        BLANK = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) put(10'(i), 10'd100, 3'd0, 8'(i + 1));
            else filler();
            tick();
            checks++;
            if (s_wr !== 4'(satn(exp_wr, 4))) begin
                errors++;
                $display("FAIL sat_step%0d got %0d want %0d", i, s_wr, satn(exp_wr, 4));
            end
        end
        BLANK = 1'b0;
        tick();
        checks++;
        if (s_wr !== 4'd15 || WR_CNT !== 16'd20 || s_drop !== 4'd0) begin
            errors++;
            $display("FAIL sat_final swr=%0d wr=%0d sdrop=%0d want 15/20/0", s_wr, WR_CNT, s_drop);
        end
    endtask

    task automatic test_random();
        bit [9:0] pc;
        bit [9:0] pr;
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0: pc = 10'($urandom);
                1: pc = 10'(639 + $urandom % 2);
                default: pc = 10'($urandom % 640);
            endcase
            case ($urandom % 4)
                0: pr = 10'($urandom);
                1: pr = 10'(479 + $urandom % 2);
                default: pr = 10'($urandom % 480);
            endcase
            RST = ($urandom % 64 == 0);
            put(pc, pr, 3'($urandom), ($urandom % 4 == 0) ? 8'h00 : 8'($urandom));
            BLANK = ($urandom % 8 != 0);
            tick();
            checks++;
            if (FB_WE !== exp_we || (exp_we && (FB_ADDR !== exp_addr || FB_DATA !== exp_data))) begin
                errors++;
                $display("FAIL rand_write cyc%0d we=%0b addr=%0d data=%0h want %0b/%0d/%0h",
                         i, FB_WE, FB_ADDR, FB_DATA, exp_we, exp_addr, exp_data);
            end
            checks++;
            if (WR_CNT !== 16'(satn(exp_wr, 16)) || DROP_CNT !== 16'(satn(exp_drop, 16)) ||
                s_wr !== 4'(satn(exp_wr, 4)) || s_drop !== 4'(satn(exp_drop, 4))) begin
                errors++;
                $display("FAIL rand_cnt cyc%0d wr=%0d drop=%0d swr=%0d sdrop=%0d want %0d/%0d/%0d/%0d",
                         i, WR_CNT, DROP_CNT, s_wr, s_drop, satn(exp_wr, 16), satn(exp_drop, 16),
                         satn(exp_wr, 4), satn(exp_drop, 4));
            end
            checks++;
            if (ROM_ADDR !== {CURRENT_INS[9:4], SID_ROW, SID_CLM}) begin
                errors++;
                $display("FAIL rand_rom cyc%0d got %h", i, ROM_ADDR);
            end
        end
        RST = 1'b0;
        BLANK = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom);
        RST = 1'b1;
        set_px(1'b0, 6'd0, 3'd0, 5'd0, 5'd0, 10'd0, 10'd0);
        exp_we = 0; exp_addr = '0; exp_data = '0; exp_wr = 0; exp_drop = 0;
        test_reset();
        test_single();
        test_drop();
        test_clip();
        test_flush();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
